// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing controller: ALU op codes, FSM states and the
// legal-op check.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request, response and ALU-side signals of the ALU-sharing controller.
// slave is the controller's view; master is the requesters/consumer/ALU side.
interface alu_share_ctrl_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [4*NREQ-1:0]  req_op;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_ready;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_y;
    logic               rsp_zero;
    logic               rsp_err;

    logic [3:0]         alu_op;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [31:0]        alu_y;
    logic               alu_zero;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_y, alu_zero,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err, alu_op, alu_a, alu_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_y, alu_zero,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err, alu_op, alu_a, alu_b
    );

endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap and grants the
// first valid request. The pointer register lives in the parent.
module rr_arb #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id
);
    localparam int unsigned PW = $clog2(NREQ);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (en && !found && req[PW'(idx)]) begin
                found          = 1'b1;
                gnt[PW'(idx)]  = 1'b1;
                gnt_id         = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between NREQ requesters: round-robin accept in IDLE, one cycle
// of ALU evaluation in EXEC, registered response held in RESP until consumed.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input logic             clk,
    input logic             rst_n,
    alu_share_ctrl_if.slave bus
);
    localparam int unsigned PW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [3:0]      op_q, op_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [31:0]     y_q, y_d;
    logic            zero_q, zero_d;
    logic            err_q, err_d;
    logic [IDW-1:0]  rid_q, rid_d;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_id;
    logic            arb_en;
    logic [3:0]      sel_op;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;

    assign arb_en = (state_q == S_IDLE);

    rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_op = bus.req_op[4*i +: 4];
                sel_a  = bus.req_a[32*i +: 32];
                sel_b  = bus.req_b[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        y_d     = y_q;
        zero_d  = zero_q;
        err_d   = err_q;
        rid_d   = rid_q;
        unique case (state_q)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = IDW'(gnt_id);
                    ptr_d   = gnt_id;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Illegal ops still report the ALU's A==B flag but never its result.
                y_d     = op_legal(op_q) ? bus.alu_y : 32'd0;
                zero_d  = bus.alu_zero;
                err_d   = !op_legal(op_q);
                rid_d   = id_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= PW'(NREQ - 1);
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            y_q     <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            rid_q   <= rid_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = rid_q;
    assign bus.rsp_y     = y_q;
    assign bus.rsp_zero  = zero_q;
    assign bus.rsp_err   = err_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed cases then randomized traffic against a
// transaction-level model (round-robin pick plus plain ALU arithmetic).
module tb_alu_share_ctrl;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic        v   [NREQ];
    logic [3:0]  op  [NREQ];
    logic [31:0] a   [NREQ];
    logic [31:0] b   [NREQ];
    int          last;

    alu_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    alu_share_ctrl #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU placed beside the controller; junk for unknown ops so forcing is visible.
    always_comb begin
        case (bus.alu_op)
            4'b0000: bus.alu_y = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_y = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_y = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_y = bus.alu_a - bus.alu_b;
            4'b0111: bus.alu_y = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
            default: bus.alu_y = 32'hDEAD_BEEF;
        endcase
        bus.alu_zero = (bus.alu_a == bus.alu_b);
    end

    function automatic bit is_legal(input logic [3:0] o);
        return (o == 4'd0) || (o == 4'd1) || (o == 4'd2) || (o == 4'd6) || (o == 4'd7);
    endfunction

    function automatic logic [31:0] model_y(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        if (!is_legal(o)) return 32'd0;
        if (o == 4'd0) return x & y;
        if (o == 4'd1) return x | y;
        if (o == 4'd2) return x + y;
        if (o == 4'd6) return x - y;
        return (x < y) ? 32'd1 : 32'd0;
    endfunction

    // Next winner: first valid requester after the last one served, wrapping.
    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]        = v[i];
            bus.req_op[4*i +: 4]    = op[i];
            bus.req_a[32*i +: 32]   = a[i];
            bus.req_b[32*i +: 32]   = b[i];
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] o, input logic [31:0] x,
                           input logic [31:0] y);
        v[i]  = 1'b1;
        op[i] = o;
        a[i]  = x;
        b[i]  = y;
    endtask

    task automatic rand_req(input int i);
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        case ($urandom_range(0, 6))
            0:       o = 4'd0;
            1:       o = 4'd1;
            2:       o = 4'd2;
            3:       o = 4'd6;
            4:       o = 4'd7;
            default: o = 4'($urandom);
        endcase
        x = $urandom;
        y = ($urandom_range(0, 3) == 0) ? x : $urandom;
        set_req(i, o, x, y);
    endtask

    // One full transaction from an IDLE cycle: accept, EXEC, RESP held for bp cycles.
    task automatic serve(input int bp, input bit refill);
        int          w;
        logic [3:0]  eop;
        logic [31:0] ea;
        logic [31:0] eb;
        w = pick();
        chk("req_ready", 32'(bus.req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w < 0) return;
        eop = op[w];
        ea  = a[w];
        eb  = b[w];
        @(posedge clk);
        #1;
        last = w;
        if (refill) rand_req(w);
        else v[w] = 1'b0;
        drive();
        chk("exec_ready", 32'(bus.req_ready), 32'd0);
        chk("exec_valid", 32'(bus.rsp_valid), 32'd0);
        chk("alu_op", 32'(bus.alu_op), 32'(eop));
        chk("alu_a", bus.alu_a, ea);
        chk("alu_b", bus.alu_b, eb);
        @(posedge clk);
        #1;
        for (int k = 0; k <= bp; k++) begin
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_id", 32'(bus.rsp_id), 32'(w));
            chk("rsp_y", bus.rsp_y, model_y(eop, ea, eb));
            chk("rsp_zero", 32'(bus.rsp_zero), 32'(ea == eb));
            chk("rsp_err", 32'(bus.rsp_err), 32'(!is_legal(eop)));
            chk("resp_ready", 32'(bus.req_ready), 32'd0);
            if (k == bp) bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b0;
        #1;
        chk("idle_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) begin
            v[i]  = 1'b0;
            op[i] = '0;
            a[i]  = '0;
            b[i]  = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        bus.rsp_ready = 1'b0;
        drive();
        last = NREQ - 1;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_y", bus.rsp_y, 32'd0);
        chk("rst_flags", {29'd0, bus.rsp_zero, bus.rsp_err, 1'b0}, 32'd0);
        chk("rst_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("rst_alu_ab", bus.alu_a | bus.alu_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        do_reset();

        // Idle with nothing valid stays idle.
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ready", 32'(bus.req_ready), 32'd0);
        chk("idle_rsp", 32'(bus.rsp_valid), 32'd0);

        set_req(0, 4'b0010, 32'd7, 32'd5);
        drive();
        serve(0, 1'b0);
        set_req(0, 4'b0110, 32'd9, 32'd9);
        drive();
        serve(0, 1'b0);
        set_req(0, 4'b0111, 32'd3, 32'd5);
        drive();
        serve(0, 1'b0);
        set_req(0, 4'b0111, 32'hFFFF_FFFF, 32'd1);
        drive();
        serve(0, 1'b0);
        set_req(1, 4'b0000, 32'h0000_00F0, 32'h0000_000F);
        drive();
        serve(0, 1'b0);
        set_req(3, 4'b0011, 32'd4, 32'd4);
        drive();
        serve(0, 1'b0);

        // Reset during EXEC drops the op; pointer returns to NREQ-1.
        set_req(2, 4'b0010, 32'd1, 32'd2);
        drive();
        @(posedge clk);
        #1;
        v[2] = 1'b0;
        drive();
        rst_n = 1'b0;
        #1;
        chk("rst_exec_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_exec_alu", bus.alu_a | bus.alu_b | 32'(bus.alu_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last = NREQ - 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
        end
        set_req(0, 4'b0001, 32'h1200, 32'h0034);
        set_req(1, 4'b0010, 32'd10, 32'd20);
        drive();
        serve(0, 1'b0);
        serve(0, 1'b0);

        // Fairness with all four continuously valid, then backpressure.
        do_reset();
        for (int i = 0; i < NREQ; i++) rand_req(i);
        drive();
        repeat (5) serve(0, 1'b1);
        serve(5, 1'b1);
        repeat (3) serve($urandom_range(0, 2), 1'b1);

        // Random traffic with sparse valids.
        clear_all();
        drive();
        repeat (40) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) rand_req(i);
            end
            if (!(v[0] || v[1] || v[2] || v[3])) rand_req($urandom_range(0, NREQ - 1));
            drive();
            serve($urandom_range(0, 2), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
